zuma_config_loader: RTL

- Streaming configuration loader for the ZUMA overlay.
- It accepts configuration words from an external valid/ready source and packs them into CONFIG_WIDTH-bit entries.
- It writes each entry into the overlay at sequential addresses, then pulses the overlay flip-flop reset once.
- It sits directly upstream of ZUMA_custom_generated and replaces the fixed ROM plus counter, so the overlay can be reprogrammed at run time.

---
 rtl/zuma_config_loader_pkg.sv | 26 ++
 rtl/zuma_config_loader_if.sv | 28 ++
 rtl/zuma_config_loader_packer.sv | 69 ++++++
 rtl/zuma_config_loader.sv | 115 +++++++++++
 4 files changed

// File: rtl/zuma_config_loader_pkg.sv
// Shared types and sizing helpers for the ZUMA configuration loader.
package zuma_config_loader_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_VRST,
    ST_RUN
  } state_t;

  // Stream words needed to cover one configuration entry.
  function automatic int unsigned words_per_entry(input int unsigned cfg_w,
                                                  input int unsigned word_w);
    return (cfg_w + word_w - 1) / word_w;
  endfunction

  // Total configuration entries in the overlay.
  function automatic longint unsigned num_entries(input int unsigned lut_size,
                                                  input int unsigned num_stages);
    return (64'd1 << lut_size) * 64'(num_stages);
  endfunction

endpackage

// File: rtl/zuma_config_loader_if.sv
// Stream-in / overlay-out signal bundle; slave is the loader, master the host side.
interface zuma_config_loader_if
  import zuma_config_loader_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = 40,
  parameter int unsigned WORD_WIDTH   = 16
);
  logic                    start;
  logic [WORD_WIDTH-1:0]   s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [CONFIG_WIDTH-1:0] config_data;
  logic                    config_en;
  logic [ADDR_W-1:0]       config_addr;
  logic                    ffrst;
  logic                    busy;
  logic                    done;

  modport master (
    output start, s_data, s_valid,
    input  s_ready, config_data, config_en, config_addr, ffrst, busy, done
  );

  modport slave (
    input  start, s_data, s_valid,
    output s_ready, config_data, config_en, config_addr, ffrst, busy, done
  );
endinterface

// File: rtl/zuma_config_loader_packer.sv
// Packs stream words LSB-first into one entry, optionally bit-reversing it.
module zuma_cfg_packer
  import zuma_config_loader_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = 40,
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned REVERSE      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic [WORD_WIDTH-1:0]   i_word,
  output logic                    o_full_c,
  output logic [CONFIG_WIDTH-1:0] o_entry
);
  localparam int unsigned W      = words_per_entry(CONFIG_WIDTH, WORD_WIDTH);
  localparam int unsigned PACK_W = W * WORD_WIDTH;
  localparam int unsigned KW     = (W > 1) ? $clog2(W) : 1;

  logic [KW-1:0]           r_k;
  logic [PACK_W-1:0]       r_pack;
  logic [PACK_W-1:0]       w_pack;
  logic [CONFIG_WIDTH-1:0] w_fwd;
  logic [CONFIG_WIDTH-1:0] w_out;
  logic [CONFIG_WIDTH-1:0] r_entry;

  // Entry completes on the handshake carrying the last word.
  assign o_full_c = i_push && (r_k == KW'(W - 1));
  assign w_fwd    = w_pack[CONFIG_WIDTH-1:0];
  assign o_entry  = r_entry;

  // Merge the incoming word into its slot; bits above CONFIG_WIDTH are dropped by w_fwd.
  always_comb begin
    w_pack = r_pack;
    for (int i = 0; i < int'(W); i++) begin
      if (r_k == KW'(i)) w_pack[i*WORD_WIDTH +: WORD_WIDTH] = i_word;
    end
  end

  // Optional bit reversal of the completed entry.
  always_comb begin
    w_out = '0;
    for (int i = 0; i < int'(CONFIG_WIDTH); i++) begin
      w_out[i] = (REVERSE != 0) ? w_fwd[CONFIG_WIDTH-1-i] : w_fwd[i];
    end
  end

  // Word index, partial pack and held entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k     <= '0;
      r_pack  <= '0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_k    <= '0;
      r_pack <= '0;
    end else if (i_push) begin
      r_pack <= w_pack;
      if (o_full_c) begin
        r_k     <= '0;
        r_entry <= w_out;
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

endmodule

// File: rtl/zuma_config_loader.sv
// Streams configuration entries into the ZUMA overlay, then pulses its flip-flop reset.
module zuma_config_loader
  import zuma_config_loader_pkg::*;
#(
  parameter int unsigned LUT_SIZE     = 6,
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned CONFIG_WIDTH = 40,
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned REVERSE      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  zuma_config_loader_if.slave  bus
);
  localparam longint unsigned N = num_entries(LUT_SIZE, NUM_STAGES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 64'd1);

  if (N == 64'd0 || N > 64'h1_0000_0000) begin : g_bad_n
    $error("zuma_config_loader: entry count does not fit the 32-bit address");
  end

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_clear;
  logic                    w_addr_inc;
  logic                    w_push;
  logic                    w_full_c;
  logic [CONFIG_WIDTH-1:0] w_entry;
  logic [ADDR_W-1:0]       r_addr;
  logic [ADDR_W-1:0]       r_cfg_addr;
  logic                    r_s_ready;
  logic                    r_config_en;
  logic                    r_ffrst;
  logic                    r_busy;
  logic                    r_done;

  assign w_push = bus.s_valid & r_s_ready;

  zuma_cfg_packer #(
    .CONFIG_WIDTH (CONFIG_WIDTH),
    .WORD_WIDTH   (WORD_WIDTH),
    .REVERSE      (REVERSE)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_push   (w_push),
    .i_word   (bus.s_data),
    .o_full_c (w_full_c),
    .o_entry  (w_entry)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and counter control; start only matters in IDLE and RUN.
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_addr_inc = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (bus.start) begin
          w_next  = ST_LOAD;
          w_clear = 1'b1;
        end
      end
      ST_LOAD:  if (w_full_c) w_next = ST_WRITE;
      ST_WRITE: begin
        if (r_addr == LAST_ADDR) begin
          w_next = ST_VRST;
        end else begin
          w_next     = ST_LOAD;
          w_addr_inc = 1'b1;
        end
      end
      ST_VRST:  w_next = ST_RUN;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; address latched entering WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_cfg_addr  <= '0;
      r_s_ready   <= 1'b0;
      r_config_en <= 1'b0;
      r_ffrst     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_s_ready   <= (w_next == ST_LOAD);
      r_config_en <= (w_next == ST_WRITE);
      r_ffrst     <= (w_next == ST_VRST);
      r_busy      <= (w_next == ST_LOAD) || (w_next == ST_WRITE) || (w_next == ST_VRST);
      r_done      <= (w_next == ST_RUN);
      if (w_clear)         r_addr <= '0;
      else if (w_addr_inc) r_addr <= r_addr + ADDR_W'(1);
      if (w_next == ST_WRITE) r_cfg_addr <= r_addr;
    end
  end

  assign bus.s_ready     = r_s_ready;
  assign bus.config_data = w_entry;
  assign bus.config_en   = r_config_en;
  assign bus.config_addr = r_cfg_addr;
  assign bus.ffrst       = r_ffrst;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
